// File: rtl/dl_pkg.sv
// dl_pkg: shared state encoding, parameter defaults and FIFO entry layout for the download router
package dl_pkg;
  localparam int NCH_DEF   = 4;
  localparam int AW_DEF    = 24;
  localparam int DEPTH_DEF = 8;
  localparam int AW_MAX    = 28;
  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_SKIP, S_DRAIN, S_DONE} state_e;
  // Address field sized for the widest supported AW; narrower builds zero-pad it.
  typedef struct packed {
    logic [AW_MAX-1:0] addr;
    logic [7:0]        data;
  } entry_t;
endpackage

// File: rtl/dl_fifo.sv
// dl_fifo: power-of-two synchronous FIFO with occupancy count; pushes into a full FIFO are dropped
module dl_fifo
  import dl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = cnt_q == (PW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(do_push);
      rd_q  <= rd_q + PW'(do_pop);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/dl_router.sv
// dl_router: steers HPS ioctl download bytes to the channel claiming the file index,
// offsetting by that channel's base address, through a FIFO to a ready/valid output.
module dl_router
  import dl_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [AW-1:0]     ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic [NCH*8-1:0]  idx_map,
  input  logic [NCH*AW-1:0] base_addr,
  output logic [NCH-1:0]    dn_go,
  output logic              dn_wr,
  input  logic              dn_ready,
  output logic [AW-1:0]     dn_addr,
  output logic [7:0]        dn_data,
  output logic [CW-1:0]     dn_ch,
  output logic [NCH-1:0]    dn_done,
  output logic [AW-1:0]     dn_len,
  output logic              overflow
);
  localparam int CNTW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, hit_ch, dn_ch_q, dn_ch_d;
  logic [AW-1:0] base_q, base_d, cnt_q, cnt_d, len_q, len_d, addr_q, addr_d, sum;
  logic [7:0] data_q, data_d;
  logic prev_q, ovf_q, wr_q, wr_d, hit, push, pop, full, empty, xfer, start, unused_addr;
  logic [CNTW-1:0] count;
  entry_t wentry, rentry;
  assign sum         = ioctl_addr + base_q;
  assign wentry      = '{addr: AW_MAX'(sum), data: ioctl_dout};
  assign push        = state_q == S_ACTIVE && ioctl_wr;
  assign xfer        = wr_q && dn_ready;
  assign pop         = !empty && (!wr_q || dn_ready);
  assign start       = state_q == S_IDLE && ioctl_download && !prev_q;
  assign unused_addr = &{1'b0, rentry.addr};
  dl_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // Scan downward so the lowest matching channel is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_ch = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (idx_map[8*c +: 8] == ioctl_index) begin
        hit = 1'b1;
        hit_ch = CW'(c);
      end
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    base_d = base_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = hit ? S_ACTIVE : S_SKIP;
        ch_d = hit_ch;
        base_d = base_addr[AW*hit_ch +: AW];
      end
      S_ACTIVE: if (!ioctl_download) state_d = S_DRAIN;
      S_SKIP:   if (!ioctl_download) state_d = S_IDLE;
      S_DRAIN:  if (empty && !wr_q) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end
  assign cnt_d   = start ? '0 : (xfer && !(&cnt_q)) ? cnt_q + AW'(1) : cnt_q;
  assign len_d   = (state_q == S_DRAIN && state_d == S_DONE) ? cnt_q : len_q;
  assign wr_d    = pop || (wr_q && !dn_ready);
  assign addr_d  = pop ? rentry.addr[AW-1:0] : addr_q;
  assign data_d  = pop ? rentry.data : data_q;
  assign dn_ch_d = pop ? ch_q : dn_ch_q;
  // prev_q resets high so a download already active at release is not a start;
  // it is forced low in DRAIN/DONE so a held-off request is seen on reaching IDLE.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      prev_q  <= 1'b1;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dn_ch_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      prev_q  <= (state_q == S_DRAIN || state_q == S_DONE) ? 1'b0 : ioctl_download;
      ovf_q   <= ovf_q || (push && full);
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dn_ch_q <= dn_ch_d;
    end
  assign ioctl_wait = state_q == S_DRAIN || (state_q == S_ACTIVE && 32'(count) >= DEPTH - 2);
  assign dn_go      = (state_q == S_ACTIVE || state_q == S_DRAIN || state_q == S_DONE) ? NCH'(1) << ch_q : '0;
  assign dn_done    = state_q == S_DONE ? NCH'(1) << ch_q : '0;
  assign dn_wr      = wr_q;
  assign dn_addr    = addr_q;
  assign dn_data    = data_q;
  assign dn_ch      = dn_ch_q;
  assign dn_len     = len_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_dl_router.sv
// tb_dl_router: directed table-driven routing vectors plus hand-written multi-cycle sequences
module tb_dl_router;
  localparam int NCH = 4, AW = 24, DEPTH = 8;
  localparam logic [NCH*AW-1:0] B0 = {24'h300000, 24'h200000, 24'h010000, 24'h100000};
  localparam logic [NCH*AW-1:0] B1 = {24'h300000, 24'h200000, 24'hFFFFFE, 24'h100000};
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic ioctl_download = 1'b0, ioctl_wr = 1'b0, ioctl_wait;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic [NCH*8-1:0] idx_map = '0;
  logic [NCH*AW-1:0] base_addr = '0;
  logic [NCH-1:0] dn_go, dn_done;
  logic dn_wr, dn_ready = 1'b1, overflow;
  logic [AW-1:0] dn_addr, dn_len;
  logic [7:0] dn_data;
  logic [1:0] dn_ch;
  int n_chk = 0, n_fail = 0;
  logic [AW-1:0] cap_addr[$];
  logic [7:0] cap_data[$];
  logic [1:0] cap_ch[$];
  int done_cnt = 0, wr_seen = 0;
  logic [NCH-1:0] done_seen = '0;

  dl_router #(.NCH(NCH), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .idx_map(idx_map), .base_addr(base_addr), .dn_go(dn_go), .dn_wr(dn_wr), .dn_ready(dn_ready),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_ch(dn_ch), .dn_done(dn_done), .dn_len(dn_len),
    .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Inputs change 2 time units after the rising edge, so the falling edge sees settled handshakes.
  always @(negedge clk_sys) begin
    if (dn_wr && dn_ready) begin
      cap_addr.push_back(dn_addr);
      cap_data.push_back(dn_data);
      cap_ch.push_back(dn_ch);
    end
    if (|dn_done) begin
      done_cnt++;
      done_seen |= dn_done;
    end
    if (dn_wr) wr_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic clear_mon();
    cap_addr.delete();
    cap_data.delete();
    cap_ch.delete();
    done_seen = '0;
    wr_seen = 0;
  endtask

  task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) wr_byte(AW'(i), 8'h10 + 8'(i));
  endtask

  task automatic finish_dl(input int budget);
    int d0;
    d0 = done_cnt;
    ioctl_download = 1'b0;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk("done_pulse", done_cnt - d0, 1);
    tick();
  endtask

  typedef struct {
    logic [NCH*8-1:0]  map;
    logic [NCH*AW-1:0] base;
    logic [7:0]        idx;
    logic [AW-1:0]     addr;
    logic [7:0]        data;
    logic [NCH-1:0]    go;
    logic [1:0]        ch;
    logic [AW-1:0]     exp_addr;
  } vec_t;
  vec_t tv[6];
  logic [AW-1:0] wrap_a[4];
  logic [AW-1:0] seq_a[4];
  logic [7:0] seq_d[4];

  initial begin
    int d0, b;
    tv[0] = '{32'h04030201, B0, 8'd2, 24'h000005, 8'hA5, 4'b0010, 2'd1, 24'h010005};
    tv[1] = '{32'h04030201, B0, 8'd4, 24'h000010, 8'h3C, 4'b1000, 2'd3, 24'h300010};
    tv[2] = '{32'h04030201, B0, 8'd1, 24'h000000, 8'h5A, 4'b0001, 2'd0, 24'h100000};
    tv[3] = '{32'h01050601, B0, 8'd1, 24'h000007, 8'hC3, 4'b0001, 2'd0, 24'h100007};
    tv[4] = '{32'h01050601, B0, 8'd5, 24'h000020, 8'h0F, 4'b0100, 2'd2, 24'h200020};
    tv[5] = '{32'h04030201, B1, 8'd2, 24'h000003, 8'hF0, 4'b0010, 2'd1, 24'h000001};
    wrap_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    seq_a = '{24'h010000, 24'h010001, 24'h010002, 24'h010003};
    seq_d = '{8'h11, 8'h22, 8'h33, 8'h44};

    tick(2);
    chk("rst_go", dn_go, 0);
    chk("rst_wr", dn_wr, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_len", dn_len, 0);
    reset_n = 1'b1;
    tick(2);

    // Single-byte routing vectors; map/base/index are scrambled mid-transfer to prove latching.
    foreach (tv[r]) begin
      idx_map = tv[r].map;
      base_addr = tv[r].base;
      ioctl_index = tv[r].idx;
      clear_mon();
      ioctl_download = 1'b1;
      tick();
      chk("row_go", dn_go, tv[r].go);
      wr_byte(tv[r].addr, tv[r].data);
      idx_map = '0;
      base_addr = '1;
      ioctl_index = 8'hEE;
      finish_dl(20);
      chk("row_count", cap_addr.size(), 1);
      if (cap_addr.size() == 1) begin
        chk("row_addr", cap_addr[0], tv[r].exp_addr);
        chk("row_data", cap_data[0], tv[r].data);
        chk("row_ch", cap_ch[0], tv[r].ch);
      end
      chk("row_done", done_seen, tv[r].go);
      chk("row_len", dn_len, 1);
      chk("row_go_after", dn_go, 0);
    end

    // Four-byte download to channel 1 with first-word latency check.
    idx_map = 32'h04030201;
    base_addr = B0;
    ioctl_index = 8'd2;
    clear_mon();
    ioctl_download = 1'b1;
    tick();
    wr_byte(0, 8'h11);
    chk("lat_cycle1_wr", dn_wr, 0);
    wr_byte(1, 8'h22);
    chk("lat_cycle2_wr", dn_wr, 1);
    wr_byte(2, 8'h33);
    wr_byte(3, 8'h44);
    finish_dl(20);
    chk("seq4_count", cap_addr.size(), 4);
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
      chk("seq4_addr", cap_addr[i], seq_a[i]);
      chk("seq4_data", cap_data[i], seq_d[i]);
      chk("seq4_ch", cap_ch[i], 1);
    end
    chk("seq4_done", done_seen, 4'b0010);
    chk("seq4_len", dn_len, 4);

    // Backpressure: wait rises at occupancy 6, output held stable, nothing lost.
    clear_mon();
    dn_ready = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) wr_byte(AW'(i), 8'h60 + 8'(i));
    chk("wait_occ5", ioctl_wait, 0);
    wr_byte(6, 8'h66);
    chk("wait_occ6", ioctl_wait, 1);
    tick(3);
    chk("hold_wr", dn_wr, 1);
    chk("hold_addr", dn_addr, 24'h010000);
    chk("hold_data", dn_data, 8'h60);
    dn_ready = 1'b1;
    for (int i = 7; i < 10; i++) begin
      b = 0;
      while (ioctl_wait && b < 20) begin
        tick();
        b++;
      end
      chk("wait_release", ioctl_wait, 0);
      wr_byte(AW'(i), 8'h60 + 8'(i));
    end
    dn_ready = 1'b0;
    ioctl_download = 1'b0;
    tick(2);
    chk("wait_in_drain", ioctl_wait, 1);
    chk("go_in_drain", dn_go, 4'b0010);
    dn_ready = 1'b1;
    finish_dl(40);
    chk("bp_count", cap_addr.size(), 10);
    for (int i = 0; i < 10 && i < cap_addr.size(); i++) begin
      chk("bp_addr", cap_addr[i], 24'h010000 + i);
      chk("bp_data", cap_data[i], 8'h60 + i);
    end
    chk("bp_ovf", overflow, 0);
    chk("bp_len", dn_len, 10);

    // Unclaimed index: everything is discarded silently.
    clear_mon();
    ioctl_index = 8'd9;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    chk("skip_go", dn_go, 0);
    burst(3);
    chk("skip_wait", ioctl_wait, 0);
    ioctl_download = 1'b0;
    tick(6);
    chk("skip_wr", wr_seen, 0);
    chk("skip_count", cap_addr.size(), 0);
    chk("skip_done", done_cnt - d0, 0);

    // Address wrap modulo 2^AW.
    clear_mon();
    base_addr = B1;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    burst(4);
    finish_dl(20);
    chk("wrap_count", cap_addr.size(), 4);
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) chk("wrap_addr", cap_addr[i], wrap_a[i]);

    // Overrun: ignore wait with the output stalled; the tenth byte is dropped.
    clear_mon();
    base_addr = B0;
    dn_ready = 1'b0;
    ioctl_download = 1'b1;
    tick();
    burst(10);
    chk("ovf_set", overflow, 1);
    dn_ready = 1'b1;
    finish_dl(40);
    chk("ovf_count", cap_addr.size(), 9);
    if (cap_data.size() == 9) chk("ovf_last", cap_data[8], 8'h18);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_len", dn_len, 9);

    // Reset mid-transfer with bytes queued; no restart until download toggles.
    dn_ready = 1'b0;
    ioctl_download = 1'b1;
    tick();
    burst(3);
    tick();
    chk("pre_rst_go", dn_go, 4'b0010);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    clear_mon();
    chk("mrst_go", dn_go, 0);
    chk("mrst_wr", dn_wr, 0);
    chk("mrst_done", dn_done, 0);
    chk("mrst_wait", ioctl_wait, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_addr", dn_addr, 0);
    chk("mrst_data", dn_data, 0);
    chk("mrst_ch", dn_ch, 0);
    chk("mrst_len", dn_len, 0);
    tick();
    reset_n = 1'b1;
    dn_ready = 1'b1;
    tick(5);
    chk("post_rst_go", dn_go, 0);
    chk("post_rst_wr", wr_seen, 0);
    chk("post_rst_done", done_cnt - d0, 0);
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    chk("restart_go", dn_go, 4'b0010);
    wr_byte(5, 8'h77);
    finish_dl(20);
    chk("restart_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) chk("restart_addr", cap_addr[0], 24'h010005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
